// File: rtl/uio_prbs_gen_chk_if.sv
// uio_prbs_gen_chk_if: request/response word bundle for one user-IO port.
// master = the PRBS block, slave = the AXI converter / far end.
interface uio_prbs_gen_chk_if #(
   parameter int W = 128
);
   logic         uio_rq_vld;
   logic [W-1:0] uio_rq_data;
   logic         uio_rq_afull;
   logic         uio_rs_vld;
   logic [W-1:0] uio_rs_data;
   logic         uio_rs_afull;

   modport master (
      output uio_rq_vld,
      output uio_rq_data,
      output uio_rs_afull,
      input  uio_rq_afull,
      input  uio_rs_vld,
      input  uio_rs_data
   );

   modport slave (
      input  uio_rq_vld,
      input  uio_rq_data,
      input  uio_rs_afull,
      output uio_rq_afull,
      output uio_rs_vld,
      output uio_rs_data
   );
endinterface

// File: rtl/uio_prbs_gen_chk.sv
// uio_prbs_gen_chk: PRBS-31 word generator on the request side and
// self-synchronising PRBS-31 checker on the response side of a UIO port.
module uio_prbs_gen_chk #(
   parameter int          UIO_PORTS_WIDTH = 128,
   parameter logic [30:0] SEED            = 31'h7FFF_FFFF,
   parameter int          LOSS_THRESH     = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_start,
   input  logic        i_stop,
   input  logic [31:0] i_word_cnt,
   input  logic        i_clr_stats,
   uio_prbs_gen_chk_if.master uio,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_tx_cnt,
   output logic [31:0] o_rx_cnt,
   output logic [31:0] o_err_cnt,
   output logic        o_locked,
   output logic        o_lock_loss
);

   localparam int          W      = UIO_PORTS_WIDTH;
   localparam int          CW     = $clog2(LOSS_THRESH + 1);
   localparam logic [CW-1:0] THR_M1 = CW'(LOSS_THRESH - 1);
   localparam logic [31:0] SAT    = 32'hFFFF_FFFF;

   // Next W bits of the x^31+x^28+1 sequence, first bit lands in the MSB.
   function automatic logic [W-1:0] prbs_word(input logic [30:0] s);
      logic [30:0]  st;
      logic         b;
      logic [W-1:0] w;
      st = s;
      w  = '0;
      for (int i = W - 1; i >= 0; i--) begin
         b    = st[30] ^ st[27];
         st   = {st[29:0], b};
         w[i] = b;
      end
      return w;
   endfunction

   typedef enum logic [1:0] {
      G_IDLE,
      G_RUN,
      G_DONE
   } gen_t;

   typedef enum logic {
      C_UNLOCKED,
      C_LOCKED
   } chk_t;

   gen_t         gen_q, gen_d;
   logic [30:0]  lfsr_q;
   logic [31:0]  len_q;
   logic [31:0]  tx_q;
   logic         vld_q;
   logic [W-1:0] data_q;
   logic [W-1:0] gen_w;
   logic         last_w;
   logic         emit;
   logic         go;

   chk_t         chk_q, chk_d;
   logic [30:0]  chk_s_q;
   logic [31:0]  rx_q;
   logic [31:0]  err_q;
   logic [CW-1:0] consec_q;
   logic         loss_q;
   logic [W-1:0] exp_w;
   logic         mis;
   logic         hit;
   logic         rs_lk;

   assign gen_w  = prbs_word(lfsr_q);
   assign last_w = (len_q != 32'd0) && (tx_q == len_q);
   assign go     = (gen_q != G_RUN) && i_start;
   assign emit   = (gen_q == G_RUN) && !uio.uio_rq_afull
                 && !i_stop && !last_w;

   // Generator next-state: start, abort, bounded completion.
   always_comb begin
      gen_d = gen_q;
      unique case (gen_q)
         G_IDLE, G_DONE: begin
            if (i_start) gen_d = G_RUN;
         end
         G_RUN: begin
            if (i_stop)      gen_d = G_IDLE;
            else if (last_w) gen_d = G_DONE;
         end
         default: gen_d = G_IDLE;
      endcase
   end

   // Generator state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) gen_q <= G_IDLE;
      else          gen_q <= gen_d;
   end

   // Generator datapath: reseed on start, emit one word per open cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_q <= SEED;
         len_q  <= '0;
         tx_q   <= '0;
         vld_q  <= 1'b0;
         data_q <= '0;
      end else begin
         vld_q <= emit;
         if (go) begin
            lfsr_q <= SEED;
            tx_q   <= '0;
            len_q  <= i_word_cnt;
         end else if (emit) begin
            data_q <= gen_w;
            lfsr_q <= gen_w[30:0];
            if (tx_q != SAT) tx_q <= tx_q + 32'd1;
         end
      end
   end

   assign exp_w = prbs_word(chk_s_q);
   assign rs_lk = uio.uio_rs_vld && (chk_q == C_LOCKED);
   assign mis   = exp_w != uio.uio_rs_data;
   assign hit   = rs_lk && mis && (consec_q == THR_M1);

   // Checker next-state: lock on first word, drop after a run of errors.
   always_comb begin
      chk_d = chk_q;
      unique case (chk_q)
         C_UNLOCKED: begin
            if (uio.uio_rs_vld) chk_d = C_LOCKED;
         end
         C_LOCKED: begin
            if (hit) chk_d = C_UNLOCKED;
         end
         default: chk_d = C_UNLOCKED;
      endcase
   end

   // Checker state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) chk_q <= C_UNLOCKED;
      else          chk_q <= chk_d;
   end

   // Expected-sequence state and run-of-errors counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         chk_s_q  <= '0;
         consec_q <= '0;
      end else if (uio.uio_rs_vld) begin
         if (chk_q == C_UNLOCKED) begin
            chk_s_q  <= uio.uio_rs_data[30:0];
            consec_q <= '0;
         end else begin
            chk_s_q <= exp_w[30:0];
            if (!mis || hit) consec_q <= '0;
            else             consec_q <= consec_q + CW'(1);
         end
      end
   end

   // Statistics: saturating counters, sticky loss flag, clear wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_q   <= '0;
         err_q  <= '0;
         loss_q <= 1'b0;
      end else if (i_clr_stats) begin
         rx_q   <= '0;
         err_q  <= '0;
         loss_q <= 1'b0;
      end else begin
         if (rs_lk && rx_q != SAT)         rx_q  <= rx_q + 32'd1;
         if (rs_lk && mis && err_q != SAT) err_q <= err_q + 32'd1;
         if (hit)                          loss_q <= 1'b1;
      end
   end

   assign uio.uio_rq_vld   = vld_q;
   assign uio.uio_rq_data  = data_q;
   assign uio.uio_rs_afull = 1'b0;

   assign o_busy      = (gen_q == G_RUN);
   assign o_done      = (gen_q == G_DONE);
   assign o_tx_cnt    = tx_q;
   assign o_rx_cnt    = rx_q;
   assign o_err_cnt   = err_q;
   assign o_locked    = (chk_q == C_LOCKED);
   assign o_lock_loss = loss_q;

endmodule

// File: tb/tb_uio_prbs_gen_chk.sv
// tb_uio_prbs_gen_chk: loopback bench with a bit-stream PRBS model,
// word scoreboard on the request side and run-level counter checks.
module tb_uio_prbs_gen_chk;

   localparam int          W    = 128;
   localparam logic [30:0] SEED = 31'h7FFF_FFFF;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        i_start = 1'b0;
   logic        i_stop = 1'b0;
   logic [31:0] i_word_cnt = '0;
   logic        i_clr_stats = 1'b0;
   logic        o_busy, o_done, o_locked, o_lock_loss;
   logic [31:0] o_tx_cnt, o_rx_cnt, o_err_cnt;

   logic         afull = 1'b0;
   logic         afull_rand = 1'b0;
   logic [W-1:0] rs_mask = '0;
   logic [W-1:0] flip = '0;
   int           c_lo = -1;
   int           c_hi = -1;

   uio_prbs_gen_chk_if #(.W(W)) uio ();

   assign uio.uio_rq_afull = afull;
   assign uio.uio_rs_vld   = uio.uio_rq_vld;
   assign uio.uio_rs_data  = uio.uio_rq_data ^ rs_mask;

   uio_prbs_gen_chk #(
      .UIO_PORTS_WIDTH(W),
      .SEED(SEED),
      .LOSS_THRESH(8)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .i_start(i_start),
      .i_stop(i_stop),
      .i_word_cnt(i_word_cnt),
      .i_clr_stats(i_clr_stats),
      .uio(uio),
      .o_busy(o_busy),
      .o_done(o_done),
      .o_tx_cnt(o_tx_cnt),
      .o_rx_cnt(o_rx_cnt),
      .o_err_cnt(o_err_cnt),
      .o_locked(o_locked),
      .o_lock_loss(o_lock_loss)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: the sequence x[n] = x[n-31] ^ x[n-28], seeded with the
   // 31 seed bits (seed MSB is the oldest), chopped into W-bit words.
   bit hist[$];

   function automatic void model_seed();
      logic [30:0] s;
      s = SEED;
      hist.delete();
      for (int i = 30; i >= 0; i--) hist.push_back(s[i]);
   endfunction

   function automatic logic [W-1:0] model_word();
      logic [W-1:0] w;
      bit b;
      w = '0;
      for (int i = W - 1; i >= 0; i--) begin
         b = hist[0] ^ hist[3];
         hist.push_back(b);
         void'(hist.pop_front());
         w[i] = b;
      end
      return w;
   endfunction

   // Word-level checker expectation for a run of n looped-back words
   // with words lo..hi corrupted.
   task automatic chk_model(input int n, input int lo, input int hi,
                            output int rx, output int err,
                            output bit lk, output bit loss);
      int run;
      rx = 0; err = 0; lk = 0; loss = 0; run = 0;
      for (int i = 0; i < n; i++) begin
         if (!lk) begin
            lk = 1;
            run = 0;
         end else begin
            rx++;
            if (i >= lo && i <= hi) begin
               err++;
               run++;
               if (run == 8) begin
                  lk = 0;
                  loss = 1;
                  run = 0;
               end
            end else begin
               run = 0;
            end
         end
      end
   endtask

   logic [W-1:0] exp_q[$];
   int           seen = 0;
   int           cyc = 0;
   int           first_cyc = 0;
   int           last_cyc = 0;
   int           done_cyc = 0;
   bit           done_seen = 0;
   logic [W-1:0] first_word = '0;
   logic         afull_prev = 1'b0;

   // Monitor: scoreboard pop per request word, skid check, loopback
   // corruption for the word currently on the bus.
   always @(negedge clk) begin
      logic [W-1:0] w;
      if (reset_n) begin
         if (afull_prev) chk("skid_vld", {127'd0, uio.uio_rq_vld}, '0);
         if (uio.uio_rq_vld) begin
            if (seen == 0) begin
               first_cyc  = cyc;
               first_word = uio.uio_rq_data;
            end
            last_cyc = cyc;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_empty: got word %0h expected none",
                        uio.uio_rq_data);
            end else begin
               w = exp_q.pop_front();
               chk("rq_word", uio.uio_rq_data, w);
            end
            rs_mask = (seen >= c_lo && seen <= c_hi) ? flip : '0;
            seen++;
         end
         if (o_done && !done_seen) begin
            done_seen = 1;
            done_cyc  = cyc;
         end
      end
      afull_prev = uio.uio_rq_afull;
      cyc++;
   end

   always @(posedge clk) begin
      #1;
      if (afull_rand) afull = 1'($urandom_range(1, 0));
   end

   task automatic do_reset();
      #1;
      reset_n = 1'b0;
      afull = 1'b0;
      i_start = 1'b0;
      i_stop = 1'b0;
      i_clr_stats = 1'b0;
      c_lo = -1;
      c_hi = -1;
      rs_mask = '0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   int start_cyc = 0;

   task automatic start_run(input int n, input int npush);
      @(posedge clk);
      #1;
      model_seed();
      for (int i = 0; i < npush; i++) exp_q.push_back(model_word());
      seen = 0;
      done_seen = 0;
      start_cyc = cyc;
      i_word_cnt = n;
      i_start = 1'b1;
      @(posedge clk);
      #1;
      i_start = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (!o_done && k < 5000) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("done_in_time", {127'd0, o_done}, 1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic chk_run(input string tag, input int n,
                          input int lo, input int hi);
      int rx, err;
      bit lk, loss;
      chk_model(n, lo, hi, rx, err, lk, loss);
      chk({tag, "_tx"}, W'(o_tx_cnt), W'(n));
      chk({tag, "_rx"}, W'(o_rx_cnt), W'(rx));
      chk({tag, "_err"}, W'(o_err_cnt), W'(err));
      chk({tag, "_locked"}, W'(o_locked), W'(lk));
      chk({tag, "_loss"}, W'(o_lock_loss), W'(loss));
      chk({tag, "_done"}, W'(o_done), 1);
      chk({tag, "_busy"}, W'(o_busy), 0);
      chk({tag, "_sb_left"}, W'(exp_q.size()), 0);
      chk({tag, "_seen"}, W'(seen), W'(n));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, W'(o_busy), 0);
      chk({tag, "_done"}, W'(o_done), 0);
      chk({tag, "_tx"}, W'(o_tx_cnt), 0);
      chk({tag, "_rx"}, W'(o_rx_cnt), 0);
      chk({tag, "_err"}, W'(o_err_cnt), 0);
      chk({tag, "_locked"}, W'(o_locked), 0);
      chk({tag, "_loss"}, W'(o_lock_loss), 0);
      chk({tag, "_vld"}, W'(uio.uio_rq_vld), 0);
      chk({tag, "_data"}, uio.uio_rq_data, '0);
      chk({tag, "_rs_afull"}, W'(uio.uio_rs_afull), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;

      // Reset state, then a clean bounded loopback run.
      #2;
      chk_zero("reset");
      do_reset();
      start_run(1000, 1000);
      wait_done();
      chk_run("clean", 1000, -1, -1);
      chk("first_latency", W'(first_cyc - start_cyc), 2);
      chk("vld_span", W'(last_cyc - first_cyc), 999);
      chk("done_after_last", W'(done_cyc - last_cyc), 1);
      chk("first_top28", W'(first_word[W-1:W-28]), 0);
      chk("rx_999", W'(o_rx_cnt), 999);

      // Random back-pressure.
      do_reset();
      afull_rand = 1'b1;
      start_run(1000, 1000);
      wait_done();
      afull_rand = 1'b0;
      afull = 1'b0;
      chk_run("afull", 1000, -1, -1);

      // Single flipped bit in word 500.
      do_reset();
      c_lo = 500;
      c_hi = 500;
      flip = W'(1) << 77;
      start_run(1000, 1000);
      wait_done();
      chk_run("flip1", 1000, 500, 500);
      chk("flip1_err_is_1", W'(o_err_cnt), 1);

      // Eight errored words in a row drop lock, then relock.
      do_reset();
      c_lo = 300;
      c_hi = 307;
      flip = W'(1);
      start_run(1000, 1000);
      wait_done();
      chk_run("loss8", 1000, 300, 307);
      chk("loss8_err_is_8", W'(o_err_cnt), 8);

      // Unbounded run, start ignored in RUN, stop + clear at word 37.
      do_reset();
      start_run(0, 64);
      k = 0;
      while (seen < 10 && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      i_start = 1'b1;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      while (seen < 36 && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("stop_reach36", W'(seen), 36);
      i_stop = 1'b1;
      i_clr_stats = 1'b1;
      @(posedge clk);
      #1;
      i_stop = 1'b0;
      i_clr_stats = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("stop_busy", W'(o_busy), 0);
      chk("stop_done", W'(o_done), 0);
      chk("stop_tx", W'(o_tx_cnt), 37);
      chk("stop_seen", W'(seen), 37);
      chk("clr_rx", W'(o_rx_cnt), 0);
      chk("clr_err", W'(o_err_cnt), 0);
      chk("stop_locked", W'(o_locked), 1);
      exp_q.delete();

      // Asynchronous reset mid-run, then restart from the seed word.
      do_reset();
      start_run(0, 64);
      k = 0;
      while (seen < 20 && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      reset_n = 1'b0;
      #1;
      chk_zero("async_rst");
      exp_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      start_run(3, 3);
      wait_done();
      chk("restart_tx", W'(o_tx_cnt), 3);
      chk("restart_rx", W'(o_rx_cnt), 2);
      chk("restart_err", W'(o_err_cnt), 0);
      chk("restart_sb_left", W'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
